// File: rtl/difftest_ref_checker.sv
// difftest_ref_checker: compares a snapshot of the DUT's architectural state
// (x0..x31, pc at index 32) against a reference stream that sends one
// register per beat. Reports pass/fail, the first mismatching entry, a
// saturating count of failed checks, and sticky sequencing/overrun flags.
module difftest_ref_checker #(
  parameter int XLEN = 64,
  parameter int NREG = 33,
  parameter int IDXW = 6
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 commit_valid,
  output logic                 commit_ready,
  input  logic [NREG*XLEN-1:0] dut_state,
  input  logic                 ref_valid,
  output logic                 ref_ready,
  input  logic [IDXW-1:0]      ref_idx,
  input  logic [XLEN-1:0]      ref_data,
  output logic                 check_done,
  output logic                 check_pass,
  output logic [IDXW-1:0]      mis_idx,
  output logic [XLEN-1:0]      mis_dut,
  output logic [XLEN-1:0]      mis_ref,
  output logic [31:0]          mismatch_cnt,
  output logic                 seq_err,
  output logic                 overrun
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMP  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NREG - 1);

  state_t          state_r;
  logic [XLEN-1:0] snap_r [NREG];
  logic [IDXW-1:0] cnt_r;
  logic            fail_r;

  logic            beat_s;
  logic            seq_bad_s;
  logic            mism_s;
  logic            last_s;
  logic            fail_next_s;
  logic [XLEN-1:0] snap_val_s;

  // Handshake readiness decodes straight from the state so it is valid in the
  // same cycle the FSM enters IDLE or CMP.
  assign commit_ready = (state_r == ST_IDLE);
  assign ref_ready    = (state_r == ST_CMP);

  // Per-beat compare: an out-of-order index always counts as a mismatch,
  // and the last beat folds its own result into the final verdict.
  always_comb begin
    snap_val_s  = snap_r[cnt_r];
    beat_s      = ref_valid && ref_ready;
    seq_bad_s   = (ref_idx != cnt_r);
    mism_s      = beat_s && (seq_bad_s || (snap_val_s != ref_data));
    last_s      = beat_s && (cnt_r == LAST_IDX);
    fail_next_s = fail_r || mism_s;
  end

  // Snapshot capture on commit acceptance; later dut_state changes are ignored.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) begin
        snap_r[i] <= {XLEN{1'b0}};
      end
    end else if ((state_r == ST_IDLE) && commit_valid) begin
      for (int i = 0; i < NREG; i++) begin
        snap_r[i] <= dut_state[i*XLEN +: XLEN];
      end
    end
  end

  // Check FSM with registered result outputs. check_done is raised on the
  // edge that enters DONE so the pulse coincides exactly with the DONE cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r      <= ST_IDLE;
      cnt_r        <= {IDXW{1'b0}};
      fail_r       <= 1'b0;
      check_done   <= 1'b0;
      check_pass   <= 1'b0;
      mis_idx      <= {IDXW{1'b0}};
      mis_dut      <= {XLEN{1'b0}};
      mis_ref      <= {XLEN{1'b0}};
      mismatch_cnt <= 32'd0;
      seq_err      <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      check_done <= 1'b0;
      if (commit_valid && !commit_ready) begin
        overrun <= 1'b1;
      end
      case (state_r)
        ST_IDLE: begin
          if (commit_valid) begin
            cnt_r   <= {IDXW{1'b0}};
            fail_r  <= 1'b0;
            mis_idx <= {IDXW{1'b0}};
            mis_dut <= {XLEN{1'b0}};
            mis_ref <= {XLEN{1'b0}};
            state_r <= ST_CMP;
          end
        end
        ST_CMP: begin
          if (beat_s) begin
            if (seq_bad_s) begin
              seq_err <= 1'b1;
            end
            if (mism_s && !fail_r) begin
              mis_idx <= cnt_r;
              mis_dut <= snap_val_s;
              mis_ref <= ref_data;
              fail_r  <= 1'b1;
            end
            cnt_r <= cnt_r + IDXW'(1);
            if (last_s) begin
              state_r    <= ST_DONE;
              check_done <= 1'b1;
              check_pass <= !fail_next_s;
              if (fail_next_s && (mismatch_cnt != 32'hFFFF_FFFF)) begin
                mismatch_cnt <= mismatch_cnt + 32'd1;
              end
            end
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_difftest_ref_checker.sv
// Directed bench for difftest_ref_checker: matching stream, mismatches,
// backpressure with stale dut_state, out-of-order beats, overrun, mid-check reset.
module tb_difftest_ref_checker;

  localparam int XLEN = 64;
  localparam int NREG = 33;
  localparam int IDXW = 6;

  logic                 clock = 1'b0;
  logic                 reset = 1'b0;
  logic                 commit_valid = 1'b0;
  logic                 commit_ready;
  logic [NREG*XLEN-1:0] dut_state = '0;
  logic                 ref_valid = 1'b0;
  logic                 ref_ready;
  logic [IDXW-1:0]      ref_idx = '0;
  logic [XLEN-1:0]      ref_data = '0;
  logic                 check_done;
  logic                 check_pass;
  logic [IDXW-1:0]      mis_idx;
  logic [XLEN-1:0]      mis_dut;
  logic [XLEN-1:0]      mis_ref;
  logic [31:0]          mismatch_cnt;
  logic                 seq_err;
  logic                 overrun;

  int checks = 0;
  int errors = 0;

  logic [XLEN-1:0] dut_tab [NREG];
  logic [XLEN-1:0] ref_dat [NREG];
  logic [IDXW-1:0] ref_ix  [NREG];

  difftest_ref_checker #(.XLEN(XLEN), .NREG(NREG), .IDXW(IDXW)) dut (
    .clock(clock), .reset(reset),
    .commit_valid(commit_valid), .commit_ready(commit_ready),
    .dut_state(dut_state),
    .ref_valid(ref_valid), .ref_ready(ref_ready),
    .ref_idx(ref_idx), .ref_data(ref_data),
    .check_done(check_done), .check_pass(check_pass),
    .mis_idx(mis_idx), .mis_dut(mis_dut), .mis_ref(mis_ref),
    .mismatch_cnt(mismatch_cnt), .seq_err(seq_err), .overrun(overrun)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Entry i = i*0x1111, pc = 0x80000000; reference mirrors it in order.
  task automatic load_match();
    for (int i = 0; i < NREG; i++) begin
      dut_tab[i] = 64'(i) * 64'h1111;
      ref_ix[i]  = IDXW'(i);
    end
    dut_tab[32] = 64'h8000_0000;
    for (int i = 0; i < NREG; i++) ref_dat[i] = dut_tab[i];
  endtask

  // Commits dut_tab, streams ref tables, checks the check_done cycle relative to T.
  task automatic run_check(input string tag, input bit gap, input bit stale,
                           input int pulse_cyc, input int exp_done);
    int cyc;
    int k;
    int early;
    bit acc;
    @(negedge clock);
    for (int i = 0; i < NREG; i++) dut_state[i*XLEN +: XLEN] = dut_tab[i];
    commit_valid = 1'b1;
    @(posedge clock);
    @(negedge clock);
    commit_valid = 1'b0;
    chk({tag, "_ref_ready"}, 64'(ref_ready), 64'd1);
    cyc = 0; k = 0; early = 0;
    while (k < NREG && cyc < 300) begin
      if (stale && cyc == 0) dut_state = '1;
      commit_valid = (cyc == pulse_cyc);
      ref_valid = gap ? ((cyc % 2) == 0) : 1'b1;
      ref_idx   = ref_ix[k];
      ref_data  = ref_dat[k];
      acc = ref_valid && ref_ready;
      if (check_done) early++;
      @(posedge clock);
      cyc++;
      if (acc) k++;
      @(negedge clock);
    end
    ref_valid = 1'b0;
    commit_valid = 1'b0;
    chk({tag, "_beats"}, 64'(k), 64'(NREG));
    chk({tag, "_early_done"}, 64'(early), 64'd0);
    chk({tag, "_done_cycle"}, 64'(cyc + 1), 64'(exp_done));
    chk({tag, "_check_done"}, 64'(check_done), 64'd1);
    chk({tag, "_commit_ready_done"}, 64'(commit_ready), 64'd0);
    @(negedge clock);
    chk({tag, "_done_pulse_end"}, 64'(check_done), 64'd0);
    chk({tag, "_commit_ready_idle"}, 64'(commit_ready), 64'd1);
  endtask

  initial begin
    int late;
    // Reset state
    #12;
    chk("rst_commit_ready", 64'(commit_ready), 64'd1);
    chk("rst_ref_ready", 64'(ref_ready), 64'd0);
    chk("rst_check_done", 64'(check_done), 64'd0);
    chk("rst_check_pass", 64'(check_pass), 64'd0);
    chk("rst_mis_idx", 64'(mis_idx), 64'd0);
    chk("rst_mis_dut", mis_dut, 64'd0);
    chk("rst_mis_ref", mis_ref, 64'd0);
    chk("rst_mismatch_cnt", 64'(mismatch_cnt), 64'd0);
    chk("rst_seq_err", 64'(seq_err), 64'd0);
    chk("rst_overrun", 64'(overrun), 64'd0);
    @(negedge clock);
    reset = 1'b1;

    // All match, back-to-back
    load_match();
    run_check("match", 1'b0, 1'b0, -1, 34);
    chk("match_pass", 64'(check_pass), 64'd1);
    chk("match_cnt", 64'(mismatch_cnt), 64'd0);
    chk("match_seq_err", 64'(seq_err), 64'd0);
    chk("match_overrun", 64'(overrun), 64'd0);

    // Two mismatches: first one (entry 5) is latched
    load_match();
    ref_dat[5]  = 64'hDEAD;
    ref_dat[10] = 64'hBEEF;
    run_check("two_mis", 1'b0, 1'b0, -1, 34);
    chk("two_mis_pass", 64'(check_pass), 64'd0);
    chk("two_mis_idx", 64'(mis_idx), 64'd5);
    chk("two_mis_dut", mis_dut, 64'h5555);
    chk("two_mis_ref", mis_ref, 64'hDEAD);
    chk("two_mis_cnt", 64'(mismatch_cnt), 64'd1);
    chk("two_mis_seq_err", 64'(seq_err), 64'd0);

    // Backpressure every other cycle, dut_state trashed after capture
    load_match();
    run_check("bp_stale", 1'b1, 1'b1, -1, 66);
    chk("bp_stale_pass", 64'(check_pass), 64'd1);
    chk("bp_stale_cnt", 64'(mismatch_cnt), 64'd1);
    chk("bp_stale_mis_idx_cleared", 64'(mis_idx), 64'd0);

    // Out-of-order: idx 3 in position 2, idx 2 in position 3
    load_match();
    ref_ix[2] = 6'd3;  ref_dat[2] = dut_tab[3];
    ref_ix[3] = 6'd2;  ref_dat[3] = dut_tab[2];
    run_check("ooo", 1'b0, 1'b0, -1, 34);
    chk("ooo_seq_err", 64'(seq_err), 64'd1);
    chk("ooo_pass", 64'(check_pass), 64'd0);
    chk("ooo_mis_idx", 64'(mis_idx), 64'd2);
    chk("ooo_mis_dut", mis_dut, 64'h2222);
    chk("ooo_mis_ref", mis_ref, 64'h3333);
    chk("ooo_cnt", 64'(mismatch_cnt), 64'd2);

    // Overrun: commit pulse mid-check is ignored, check completes normally
    load_match();
    run_check("overrun", 1'b0, 1'b0, 5, 34);
    chk("overrun_flag", 64'(overrun), 64'd1);
    chk("overrun_pass", 64'(check_pass), 64'd1);
    chk("overrun_cnt", 64'(mismatch_cnt), 64'd2);
    chk("overrun_seq_err_sticky", 64'(seq_err), 64'd1);

    // Reset mid-CMP with a mismatch already latched
    load_match();
    @(negedge clock);
    for (int i = 0; i < NREG; i++) dut_state[i*XLEN +: XLEN] = dut_tab[i];
    commit_valid = 1'b1;
    @(negedge clock);
    commit_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      ref_valid = 1'b1;
      ref_idx   = IDXW'(i);
      ref_data  = (i == 3) ? 64'h1 : dut_tab[i];
      @(negedge clock);
    end
    ref_valid = 1'b0;
    chk("pre_rst_ref_ready", 64'(ref_ready), 64'd1);
    chk("pre_rst_mis_idx", 64'(mis_idx), 64'd3);
    reset = 1'b0;
    #1;
    chk("midrst_commit_ready", 64'(commit_ready), 64'd1);
    chk("midrst_ref_ready", 64'(ref_ready), 64'd0);
    chk("midrst_seq_err", 64'(seq_err), 64'd0);
    chk("midrst_overrun", 64'(overrun), 64'd0);
    chk("midrst_cnt", 64'(mismatch_cnt), 64'd0);
    chk("midrst_mis_idx", 64'(mis_idx), 64'd0);
    chk("midrst_check_pass", 64'(check_pass), 64'd0);
    @(negedge clock);
    reset = 1'b1;
    late = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (check_done) late++;
    end
    chk("midrst_no_done", 64'(late), 64'd0);
    chk("midrst_idle", 64'(commit_ready), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
